pc_sequencer: RTL and testbench

- Parametrised program-counter unit for the C0 core; successor to the single-register instruction pointer.
- Generates the instruction address each cycle: sequential increment, conditional jump on a selected ALU flag, and unconditional CALL/RET through an internal return-address stack.
- Sits between the instruction decoder (JMP/CALL/RET strobes, condition field, immediate target) and instruction memory (ADDR).
- Adds a sticky fault state for stack overflow, stack underflow and illegal strobe combinations.

---
 rtl/pc_seq_pkg.sv | 27 ++
 rtl/ret_stack.sv | 66 ++++++
 rtl/pc_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the program-counter sequencer.
//   - FAULT_CODE values (FC_*)
//   - FSM state encoding (state_t)
//   - width helpers for the stack pointer and stack index
package pc_seq_pkg;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_OVF  = 2'b01;
  localparam logic [1:0] FC_UNF  = 2'b10;
  localparam logic [1:0] FC_ILL  = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  // Width needed to count 0..depth inclusive.
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width needed to address depth entries (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// ret_stack: LIFO of return addresses.
// Ports:
//   CLK, RST     clock, asynchronous active-high reset (clears count only)
//   push, pop    push din / pop top; a push while full or a pop while empty is ignored
//   din          address to push
//   top          entry at count-1 (don't-care while empty)
//   count        occupancy, 0..STACK_DEPTH
//   full, empty  occupancy flags
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              push,
  input  logic                              pop,
  input  logic [ADDR_W-1:0]                 din,
  output logic [ADDR_W-1:0]                 top,
  output logic [sp_width(STACK_DEPTH)-1:0]  count,
  output logic                              full,
  output logic                              empty
);

  localparam int SP_W    = sp_width(STACK_DEPTH);
  localparam int IDX_W   = idx_width(STACK_DEPTH);
  // Rounded up to a power of two so the index width matches the array exactly.
  localparam int ENTRIES = 1 << IDX_W;

  logic [ADDR_W-1:0] mem [ENTRIES];
  logic [SP_W-1:0]   below;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == SP_W'(STACK_DEPTH));
  assign empty   = (count == '0);
  assign below   = count - SP_W'(1);
  assign wr_idx  = count[IDX_W-1:0];
  assign rd_idx  = below[IDX_W-1:0];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign top     = mem[rd_idx];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + SP_W'(1);
        2'b01:   count <= below;
        default: count <= count;
      endcase
    end
  end

  // Contents are not reset; a pop leaves the entry in place.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-address generator with conditional jump and
// CALL/RET through an internal return stack; sticky fault on overflow,
// underflow or more than one strobe.
// Ports:
//   CLK, RST                       clock, asynchronous active-high reset
//   EN                             advance enable (0 = stall, strobes ignored)
//   JMP_INST, CALL_INST, RET_INST  decoder strobes (at most one at a time)
//   COND                           [2:0] flag select, [3] required flag value
//   FLAGS                          registered core flags
//   TARGET                         jump/call target
//   ADDR                           registered instruction address
//   SP                             return-stack occupancy
//   FAULT, FAULT_CODE              sticky fault; FAULT is high exactly in ST_FAULT
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W       = 8,
  parameter int                FLAG_W       = 8,
  parameter int                STACK_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              EN,
  input  logic                              JMP_INST,
  input  logic                              CALL_INST,
  input  logic                              RET_INST,
  input  logic [3:0]                        COND,
  input  logic [FLAG_W-1:0]                 FLAGS,
  input  logic [ADDR_W-1:0]                 TARGET,
  output logic [ADDR_W-1:0]                 ADDR,
  output logic [sp_width(STACK_DEPTH)-1:0]  SP,
  output logic                              FAULT,
  output logic [1:0]                        FAULT_CODE
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        code_q, code_d;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full, stk_empty;
  logic              push, pop;
  logic              flag_sel;
  logic              taken;
  logic              multi;

  // Wraps naturally at 2^ADDR_W; also the return address pushed by CALL.
  assign addr_inc = addr_q + ADDR_W'(1);

  // Select bits beyond FLAG_W read as 0.
  always_comb begin
    flag_sel = 1'b0;
    for (int i = 0; i < FLAG_W && i < 8; i++) begin
      if (COND[2:0] == 3'(i)) flag_sel = FLAGS[i];
    end
  end

  assign taken = (flag_sel == COND[3]);
  assign multi = (JMP_INST & CALL_INST) | (JMP_INST & RET_INST) | (CALL_INST & RET_INST);

  ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .din   (addr_inc),
    .top   (stk_top),
    .count (SP),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    code_d  = code_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (EN) begin
          if (multi) begin
            code_d  = FC_ILL;
            state_d = ST_FAULT;
          end else if (CALL_INST) begin
            if (stk_full) begin
              code_d  = FC_OVF;
              state_d = ST_FAULT;
            end else begin
              push   = 1'b1;
              addr_d = TARGET;
            end
          end else if (RET_INST) begin
            if (stk_empty) begin
              code_d  = FC_UNF;
              state_d = ST_FAULT;
            end else begin
              pop    = 1'b1;
              addr_d = stk_top;
            end
          end else if (JMP_INST && taken) begin
            addr_d = TARGET;
          end else begin
            addr_d = addr_inc;
          end
        end
      end
      // ST_FAULT: everything frozen until reset.
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_RUN;
      addr_q  <= RESET_VECTOR;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      code_q  <= code_d;
    end
  end

  assign ADDR       = addr_q;
  assign FAULT      = (state_q == ST_FAULT);
  assign FAULT_CODE = code_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer (ADDR_W=8, STACK_DEPTH=4).
// Each step drives inputs on the falling edge, advances a behavioural model,
// queues the expected {ADDR,SP,FAULT,FAULT_CODE} and checks it 1 time unit
// after the next rising edge.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int ADDR_W = 8;
  localparam int FLAG_W = 8;
  localparam int DEPTH  = 4;
  localparam int SP_W   = 3;
  localparam int W      = ADDR_W + SP_W + 1 + 2;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              EN = 1'b0;
  logic              JMP_INST = 1'b0;
  logic              CALL_INST = 1'b0;
  logic              RET_INST = 1'b0;
  logic [3:0]        COND = '0;
  logic [FLAG_W-1:0] FLAGS = '0;
  logic [ADDR_W-1:0] TARGET = '0;
  logic [ADDR_W-1:0] ADDR;
  logic [SP_W-1:0]   SP;
  logic              FAULT;
  logic [1:0]        FAULT_CODE;

  pc_sequencer #(
    .ADDR_W       (ADDR_W),
    .FLAG_W       (FLAG_W),
    .STACK_DEPTH  (DEPTH),
    .RESET_VECTOR (8'h00)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .JMP_INST   (JMP_INST),
    .CALL_INST  (CALL_INST),
    .RET_INST   (RET_INST),
    .COND       (COND),
    .FLAGS      (FLAGS),
    .TARGET     (TARGET),
    .ADDR       (ADDR),
    .SP         (SP),
    .FAULT      (FAULT),
    .FAULT_CODE (FAULT_CODE)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model + scoreboard ----------------
  logic [ADDR_W-1:0] m_addr;
  logic [SP_W-1:0]   m_sp;
  logic [ADDR_W-1:0] m_stack [DEPTH];
  logic              m_fault;
  logic [1:0]        m_code;

  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  function automatic logic [W-1:0] model_word();
    return {m_addr, m_sp, m_fault, m_code};
  endfunction

  task automatic model_reset();
    m_addr  = 8'h00;
    m_sp    = '0;
    m_fault = 1'b0;
    m_code  = 2'b00;
  endtask

  task automatic model_step(input logic en, input logic jmp, input logic call,
                            input logic ret, input logic [3:0] cond,
                            input logic [7:0] flags, input logic [7:0] target);
    int n;
    n = int'(jmp) + int'(call) + int'(ret);
    if (!m_fault && en) begin
      if (n > 1) begin
        m_fault = 1'b1;
        m_code  = 2'b11;
      end else if (call) begin
        if (m_sp == 3'(DEPTH)) begin
          m_fault = 1'b1;
          m_code  = 2'b01;
        end else begin
          m_stack[m_sp] = m_addr + 8'd1;
          m_sp   = m_sp + 3'd1;
          m_addr = target;
        end
      end else if (ret) begin
        if (m_sp == 3'd0) begin
          m_fault = 1'b1;
          m_code  = 2'b10;
        end else begin
          m_addr = m_stack[m_sp - 3'd1];
          m_sp   = m_sp - 3'd1;
        end
      end else if (jmp && (flags[cond[2:0]] == cond[3])) begin
        m_addr = target;
      end else begin
        m_addr = m_addr + 8'd1;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    obs = {ADDR, SP, FAULT, FAULT_CODE};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        fails++;
        $error("FAIL %s: observed addr=%h sp=%0d fault=%b code=%b, expected addr=%h sp=%0d fault=%b code=%b",
               tag, obs[W-1 -: 8], obs[5:3], obs[2], obs[1:0],
               exp[W-1 -: 8], exp[5:3], exp[2], exp[1:0]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic en, input logic jmp, input logic call,
                      input logic ret, input logic [3:0] cond,
                      input logic [7:0] flags, input logic [7:0] target,
                      input string tag);
    @(negedge CLK);
    EN        = en;
    JMP_INST  = jmp;
    CALL_INST = call;
    RET_INST  = ret;
    COND      = cond;
    FLAGS     = flags;
    TARGET    = target;
    model_step(en, jmp, call, ret, cond, flags, target);
    exp_q.push_back(model_word());
    @(posedge CLK);
    #1;
    check(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, tag);
  endtask

  // Reset asserted mid-cycle and checked before any rising edge.
  task automatic do_reset(input string tag);
    @(negedge CLK);
    #2;
    RST       = 1'b1;
    EN        = 1'b0;
    JMP_INST  = 1'b0;
    CALL_INST = 1'b0;
    RET_INST  = 1'b0;
    model_reset();
    exp_q.push_back(model_word());
    #1;
    check(tag);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] t;
    model_reset();

    do_reset("reset");
    idle(300, "count_wrap");

    do_reset("reset_jmp1");
    idle(16, "to_0x10");
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b1011, 8'h08, 8'h80, "jmp_taken");
    do_reset("reset_jmp2");
    idle(16, "to_0x10");
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b1011, 8'h00, 8'h80, "jmp_not_taken");
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0101, 8'hDF, 8'h33, "jmp_pol0_taken");
    for (int i = 0; i < 24; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "jmp_rand");

    do_reset("reset_call");
    idle(5, "to_0x05");
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 8'h40, "call_0x40");
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 8'h00, "ret_0x06");
    idle(2, "after_ret");
    t = m_addr + 8'd1;
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, t, "call_self_ret");
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 8'h00, "ret_self");

    do_reset("reset_nest");
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 8'(8'h20 + 8'(i * 16)), "nest_call");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'h0, 8'hFF, 8'h77, "ovf_frozen");
    do_reset("reset_mid_fault");

    step(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 8'h00, "ret_underflow");
    idle(2, "unf_frozen");

    do_reset("reset_ill");
    idle(3, "to_0x03");
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 8'h55, "illegal");
    idle(2, "ill_frozen");

    do_reset("reset_stall");
    idle(2, "to_0x02");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 8'h90, "stall_call");
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 8'h90, "stall_release");
    idle(1, "after_call");
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 8'h00, "ret_after_stall");

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $error("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
